mem_byte_arbiter: RTL and testbench

- Sequences and shares the 1024 x 8 synchronous byte memory between two requesters: port 0 (UART loader) and port 1 (CPU data side).
- Each request is a byte, halfword or word access.
- The block breaks each request into back-to-back byte accesses, little-endian, and pipelines reads around the memory's one-cycle registered dout.
- Sits directly in front of the memory; the memory's own reset is driven elsewhere.

---
 rtl/mem_byte_arbiter_if.sv | 47 ++++
 rtl/mem_byte_arbiter.sv | 118 +++++++++++
 tb/tb_mem_byte_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_arbiter_if.sv
// Requester, result and memory-side signals of the two-port byte arbiter.
// The master modport is the environment (both requesters plus the memory).
// The slave modport is the arbiter.
interface mem_byte_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              req0;
    logic              we0;
    logic [1:0]        size0;
    logic [ADDR_W-1:0] addr0;
    logic [31:0]       wdata0;
    logic              gnt0;
    logic              done0;

    logic              req1;
    logic              we1;
    logic [1:0]        size1;
    logic [ADDR_W-1:0] addr1;
    logic [31:0]       wdata1;
    logic              gnt1;
    logic              done1;

    logic [31:0]       rdata;
    logic              busy;

    logic              mem_En;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;

    modport master (
        output req0, we0, size0, addr0, wdata0,
        output req1, we1, size1, addr1, wdata1,
        input  gnt0, done0, gnt1, done1, rdata, busy,
        input  mem_En, mem_wea, mem_addr, mem_din,
        output mem_dout
    );

    modport slave (
        input  req0, we0, size0, addr0, wdata0,
        input  req1, we1, size1, addr1, wdata1,
        output gnt0, done0, gnt1, done1, rdata, busy,
        output mem_En, mem_wea, mem_addr, mem_din,
        input  mem_dout
    );
endinterface

// File: rtl/mem_byte_arbiter.sv
// Two-port round-robin arbiter in front of a byte-wide synchronous memory.
// Splits byte/half/word requests into little-endian byte accesses and
// reassembles reads around the memory's one-cycle registered dout.
//
// state  | meaning
// IDLE   | waiting for a request; grant is issued combinationally here
// ACCESS | one memory byte access per cycle, cnt = 0..N-1
// DRAIN  | read only: collect the last byte from the memory pipeline
// RESP   | pulse done for the latched port
module mem_byte_arbiter #(
    parameter int ADDR_W   = 10,
    parameter bit RST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              Rst,
    mem_byte_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              prio_q;
    logic              port_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [1:0]        cnt_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       rdata_q;

    logic              grant_any;
    logic              pick1;
    logic [1:0]        last_cnt;
    logic [1:0]        cap_idx;
    logic [31:0]       rbuf_new;

    // Arbitration: a lone request wins, a tie goes to the priority port.
    always_comb begin
        pick1     = bus.req1 && (!bus.req0 || prio_q);
        grant_any = (state_q == S_IDLE) && (bus.req0 || bus.req1);
    end

    // Last byte index of the latched request and the read-byte merge.
    always_comb begin
        last_cnt = 2'd3;
        if (size_q == 2'b00) last_cnt = 2'd0;
        else if (size_q == 2'b01) last_cnt = 2'd1;
        cap_idx  = (state_q == S_DRAIN) ? last_cnt : (cnt_q - 2'd1);
        rbuf_new = rbuf_q;
        rbuf_new[{cap_idx, 3'b000} +: 8] = bus.mem_dout;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_any) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == last_cnt) state_d = we_q ? S_RESP : S_DRAIN;
            S_DRAIN:  state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, request latches, byte counter and read assembly.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            prio_q  <= RST_PRIO;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            base_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 2'd0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        port_q  <= pick1;
                        we_q    <= pick1 ? bus.we1    : bus.we0;
                        size_q  <= pick1 ? bus.size1  : bus.size0;
                        base_q  <= pick1 ? bus.addr1  : bus.addr0;
                        wdata_q <= pick1 ? bus.wdata1 : bus.wdata0;
                        cnt_q   <= 2'd0;
                        rbuf_q  <= '0;
                        prio_q  <= ~pick1;
                    end
                end
                S_ACCESS: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (!we_q && cnt_q != 2'd0) rbuf_q <= rbuf_new;
                end
                S_DRAIN: rdata_q <= rbuf_new;
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        bus.gnt0     = grant_any && !pick1;
        bus.gnt1     = grant_any && pick1;
        bus.done0    = (state_q == S_RESP) && !port_q;
        bus.done1    = (state_q == S_RESP) && port_q;
        bus.busy     = (state_q != S_IDLE);
        bus.rdata    = rdata_q;
        bus.mem_En   = (state_q == S_ACCESS);
        bus.mem_wea  = (state_q == S_ACCESS) && we_q;
        bus.mem_addr = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
        bus.mem_din  = wdata_q[{cnt_q, 3'b000} +: 8];
    end
endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Bench for mem_byte_arbiter: behavioural 1024x8 memory, reference memory
// image, and queues of expected grants, byte accesses and completions.
module tb_mem_byte_arbiter;
    logic clk;
    logic rst;

    mem_byte_arbiter_if #(.ADDR_W(10)) bus();

    mem_byte_arbiter #(.ADDR_W(10), .RST_PRIO(1'b0)) dut (
        .clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        port;
        logic        rd;
        logic [31:0] data;
        int          lat;
    } resp_t;

    typedef struct {
        logic [9:0] addr;
        logic       we;
        logic [7:0] din;
    } acc_t;

    logic [7:0] mem     [1024];
    logic [7:0] ref_mem [1024];
    resp_t      sb[$];
    acc_t       aq[$];
    logic       gq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int gnt_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    bit done_seen = 0;
    bit spacing_on = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous memory with registered read data.
    always @(posedge clk) begin
        if (bus.mem_En) begin
            if (bus.mem_wea) mem[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: compares grants, memory accesses and completions to the queues.
    always @(negedge clk) begin
        if (rst) begin
            chk("dual_gnt", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            if (bus.gnt0 || bus.gnt1) begin
                chk("gnt_expected", 32'(gq.size() != 0), 32'd1);
                if (gq.size() != 0) chk("gnt_port", 32'(bus.gnt1), 32'(gq.pop_front()));
                if (spacing_on && done_seen) chk("gnt_gap", 32'(cyc - done_cyc), 32'd1);
                gnt_cyc = cyc;
            end
            if (bus.mem_En) begin
                chk("acc_expected", 32'(aq.size() != 0), 32'd1);
                if (aq.size() != 0) begin
                    acc_t a;
                    a = aq.pop_front();
                    chk("mem_addr", 32'(bus.mem_addr), 32'(a.addr));
                    chk("mem_wea", 32'(bus.mem_wea), 32'(a.we));
                    chk("mem_din", 32'(bus.mem_din), 32'(a.din));
                end
            end else if (bus.mem_wea) begin
                chk("wea_without_en", 32'(bus.mem_wea), 32'd0);
            end
            if (bus.done0 || bus.done1) begin
                chk("dual_done", 32'(bus.done0 & bus.done1), 32'd0);
                chk("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    resp_t r;
                    r = sb.pop_front();
                    chk("done_port", 32'(bus.done1), 32'(r.port));
                    chk("latency", 32'(cyc - gnt_cyc), 32'(r.lat));
                    if (r.rd) chk("rdata", bus.rdata, r.data);
                end
                done_cyc  = cyc;
                done_seen = 1;
                n_done++;
            end
        end
    end

    // Queue the expectations of one request, in the order it will be granted.
    task automatic push_req(input bit p, input bit we, input logic [1:0] sz,
                            input logic [9:0] a, input logic [31:0] wd);
        int n;
        logic [31:0] exp;
        logic [9:0] ad;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp = '0;
        for (int k = 0; k < n; k++) begin
            ad = a + 10'(k);
            aq.push_back('{addr: ad, we: we, din: wd[8*k +: 8]});
            if (we) ref_mem[ad] = wd[8*k +: 8];
            else    exp[8*k +: 8] = ref_mem[ad];
        end
        sb.push_back('{port: p, rd: !we, data: exp, lat: we ? n + 1 : n + 2});
        gq.push_back(p);
    endtask

    task automatic set_port(input bit p, input bit req, input bit we, input logic [1:0] sz,
                            input logic [9:0] a, input logic [31:0] wd);
        if (p) begin
            bus.req1 = req; bus.we1 = we; bus.size1 = sz; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.size0 = sz; bus.addr0 = a; bus.wdata0 = wd;
        end
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) return;
        end
        chk("gnt_timeout", 32'(bus.gnt0 | bus.gnt1), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) return;
        end
        chk("done_timeout", 32'(bus.done0 | bus.done1), 32'd1);
    endtask

    // Full single-port transaction; returns one cycle after done (IDLE).
    task automatic xact(input bit p, input bit we, input logic [1:0] sz,
                        input logic [9:0] a, input logic [31:0] wd);
        push_req(p, we, sz, a, wd);
        set_port(p, 1'b1, we, sz, a, wd);
        wait_gnt();
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        wait_done();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] sv22, sv23;
        int saved_done;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        rst = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        set_port(1'b1, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        #12;
        chk("rst_ctrl", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                             bus.mem_En, bus.mem_wea, bus.busy}), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Word write then reads of several sizes.
        xact(1'b1, 1'b1, 2'b10, 10'h010, 32'hA1B2C3D4);
        xact(1'b1, 1'b0, 2'b10, 10'h010, 32'h0);
        chk("rdata_word", bus.rdata, 32'hA1B2C3D4);
        xact(1'b1, 1'b0, 2'b00, 10'h012, 32'h0);
        chk("rdata_byte", bus.rdata, 32'h000000B2);
        xact(1'b0, 1'b0, 2'b01, 10'h012, 32'h0);
        chk("rdata_half", bus.rdata, 32'h0000A1B2);
        xact(1'b1, 1'b1, 2'b01, 10'h040, 32'hFFFF9876);
        chk("rdata_hold_on_write", bus.rdata, 32'h0000A1B2);
        xact(1'b1, 1'b0, 2'b11, 10'h03F, 32'h0);

        // Address wrap at the top of memory.
        xact(1'b0, 1'b1, 2'b10, 10'h3FE, 32'h11223344);
        xact(1'b0, 1'b0, 2'b10, 10'h3FE, 32'h0);
        chk("rdata_wrap", bus.rdata, 32'h11223344);

        // Reset in the middle of a port-0 word write (priority then points at port 1).
        xact(1'b1, 1'b1, 2'b10, 10'h020, 32'h55667788);
        sv22 = ref_mem[10'h022];
        sv23 = ref_mem[10'h023];
        push_req(1'b0, 1'b1, 2'b10, 10'h020, 32'hDEADBEEF);
        set_port(1'b0, 1'b1, 1'b1, 2'b10, 10'h020, 32'hDEADBEEF);
        wait_gnt();
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        saved_done = n_done;
        rst = 1'b0;
        #1;
        chk("abort_async", 32'({bus.mem_En, bus.mem_wea, bus.busy, bus.done0}), 32'd0);
        ref_mem[10'h022] = sv22;
        ref_mem[10'h023] = sv23;
        aq.delete();
        sb.delete();
        gq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done), 32'(saved_done));
        chk("abort_idle", 32'(bus.busy), 32'd0);

        // Both ports held: grants must alternate starting at the reset priority.
        spacing_on = 1;
        done_seen  = 0;
        push_req(1'b0, 1'b0, 2'b00, 10'h011, 32'h0);
        push_req(1'b1, 1'b0, 2'b00, 10'h3FF, 32'h0);
        push_req(1'b0, 1'b0, 2'b00, 10'h011, 32'h0);
        push_req(1'b1, 1'b0, 2'b00, 10'h3FF, 32'h0);
        set_port(1'b0, 1'b1, 1'b0, 2'b00, 10'h011, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 2'b00, 10'h3FF, 32'h0);
        for (int g = 0; g < 4; g++) wait_gnt();
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        set_port(1'b1, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        wait_done();
        @(posedge clk); #1;
        spacing_on = 0;
        chk("arb_queue_empty", 32'(gq.size()), 32'd0);

        // Aborted write left bytes 0-1 new and bytes 2-3 old.
        xact(1'b0, 1'b0, 2'b10, 10'h020, 32'h0);
        chk("rdata_abort", bus.rdata, 32'h5566BEEF);

        // Port 0 raises and drops req while port 1 is busy: never served.
        push_req(1'b1, 1'b0, 2'b10, 10'h010, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 2'b10, 10'h010, 32'h0);
        wait_gnt();
        @(posedge clk); #1;
        set_port(1'b1, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        set_port(1'b0, 1'b1, 1'b0, 2'b00, 10'h005, 32'h0);
        @(posedge clk); #1;
        chk("busy_during", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        wait_done();
        @(posedge clk); #1;
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size() + aq.size() + gq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
